// File: rtl/ladybird_bus_arbiter.sv
// Shares the core memory bus between the L1 I-cache (id 0) and L1 D-cache (id 1), one transaction in flight.
// Define LADYBIRD_BUS_ARBITER_RR_EN for round-robin tie-breaking; otherwise D wins every tie.
module ladybird_bus_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [1:0]                 s_req_valid,
    output logic [1:0]                 s_req_ready,
    input  logic [1:0][ADDR_W-1:0]     s_req_addr,
    input  logic [1:0][DATA_W-1:0]     s_req_wdata,
    input  logic [1:0][DATA_W/8-1:0]   s_req_wstrb,
    output logic [1:0]                 s_resp_valid,
    input  logic [1:0]                 s_resp_ready,
    output logic [DATA_W-1:0]          s_resp_data,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic                       m_req_id,
    output logic [ADDR_W-1:0]          m_req_addr,
    output logic [DATA_W-1:0]          m_req_wdata,
    output logic [DATA_W/8-1:0]        m_req_wstrb,
    input  logic                       m_resp_valid,
    output logic                       m_resp_ready,
    input  logic [DATA_W-1:0]          m_resp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   grant;
    logic   any_req_c;
    logic   winner_c;

    assign any_req_c = |s_req_valid;
    assign m_req_id  = grant;

`ifdef LADYBIRD_BUS_ARBITER_RR_EN
    logic last_grant;

    // On a tie the requester that did not win last time goes next.
    assign winner_c = (&s_req_valid) ? ~last_grant : s_req_valid[1];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req_c) begin
            last_grant <= winner_c;
        end
    end
`else
    // Fixed priority: D wins whenever it is requesting.
    assign winner_c = s_req_valid[1];
`endif

    // Transaction sequencing and the latched downstream request.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            grant       <= 1'b0;
            m_req_valid <= 1'b0;
            m_req_addr  <= '0;
            m_req_wdata <= '0;
            m_req_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        grant       <= winner_c;
                        m_req_addr  <= s_req_addr[winner_c];
                        m_req_wdata <= s_req_wdata[winner_c];
                        m_req_wstrb <= s_req_wstrb[winner_c];
                        m_req_valid <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (m_req_ready) begin
                        m_req_valid <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (m_resp_valid && m_resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Grant strobe in IDLE and zero-latency response routing to the owner in RESP.
    always_comb begin
        s_req_ready  = 2'b00;
        s_resp_valid = 2'b00;
        s_resp_data  = '0;
        m_resp_ready = 1'b0;
        case (state)
            IDLE: begin
                if (any_req_c) begin
                    s_req_ready[winner_c] = 1'b1;
                end
            end
            RESP: begin
                s_resp_valid[grant] = m_resp_valid;
                s_resp_data         = m_resp_data;
                m_resp_ready        = s_resp_ready[grant];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench for ladybird_bus_arbiter: requester/downstream models plus request and grant-order scoreboards.
module tb_ladybird_bus_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct {
        logic              id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    logic                     clk;
    logic                     nrst;
    logic [1:0]               s_req_valid;
    logic [1:0]               s_req_ready;
    logic [1:0][ADDR_W-1:0]   s_req_addr;
    logic [1:0][DATA_W-1:0]   s_req_wdata;
    logic [1:0][STRB_W-1:0]   s_req_wstrb;
    logic [1:0]               s_resp_valid;
    logic [1:0]               s_resp_ready;
    logic [DATA_W-1:0]        s_resp_data;
    logic                     m_req_valid;
    logic                     m_req_ready;
    logic                     m_req_id;
    logic [ADDR_W-1:0]        m_req_addr;
    logic [DATA_W-1:0]        m_req_wdata;
    logic [STRB_W-1:0]        m_req_wstrb;
    logic                     m_resp_valid;
    logic                     m_resp_ready;
    logic [DATA_W-1:0]        m_resp_data;

    ladybird_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_addr   (s_req_addr),
        .s_req_wdata  (s_req_wdata),
        .s_req_wstrb  (s_req_wstrb),
        .s_resp_valid (s_resp_valid),
        .s_resp_ready (s_resp_ready),
        .s_resp_data  (s_resp_data),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_id     (m_req_id),
        .m_req_addr   (m_req_addr),
        .m_req_wdata  (m_req_wdata),
        .m_req_wstrb  (m_req_wstrb),
        .m_resp_valid (m_resp_valid),
        .m_resp_ready (m_resp_ready),
        .m_resp_data  (m_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    req_t              req_q[$];
    logic              exp_order[$];
    int                rq_cnt[2];
    logic [ADDR_W-1:0] rq_addr[2];
    logic [DATA_W-1:0] rq_wdata[2];
    logic [STRB_W-1:0] rq_wstrb[2];
    logic [1:0]        gnt_last = 2'b00;
    bit                busy = 1'b0;
    bit                req_ph = 1'b0;
    bit                resp_ph = 1'b0;
    logic              owner = 1'b0;
    int                req_stall = 0;
    int                resp_stall = 0;
    int                req_wait = 0;
    int                rsp_wait = 0;
    int                rsp_gap = 0;
    int                resp_cnt[2];
    int                txn_no = 0;
    logic [DATA_W-1:0] cur_resp = '0;
    logic [DATA_W-1:0] last_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        tests++;
        assert (obs_v === exp_v) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_req_ready"},  64'(s_req_ready),  64'(0));
        chk({tag, "_s_resp_valid"}, 64'(s_resp_valid), 64'(0));
        chk({tag, "_m_req_valid"},  64'(m_req_valid),  64'(0));
        chk({tag, "_m_resp_ready"}, 64'(m_resp_ready), 64'(0));
        chk({tag, "_m_req_id"},     64'(m_req_id),     64'(0));
        chk({tag, "_m_req_addr"},   64'(m_req_addr),   64'(0));
        chk({tag, "_m_req_wdata"},  64'(m_req_wdata),  64'(0));
        chk({tag, "_m_req_wstrb"},  64'(m_req_wstrb),  64'(0));
        chk({tag, "_s_resp_data"},  64'(s_resp_data),  64'(0));
    endtask

    // Requesters hold until granted; downstream stalls request/response as configured.
    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (gnt_last[i]) begin
                rq_cnt[i]--;
                rq_addr[i]  += 32'h100;
                rq_wdata[i] = $urandom;
            end
            s_req_valid[i] = (rq_cnt[i] != 0);
            s_req_addr[i]  = rq_addr[i];
            s_req_wdata[i] = rq_wdata[i];
            s_req_wstrb[i] = rq_wstrb[i];
        end
        gnt_last = 2'b00;
        m_req_ready = req_ph && (req_wait == 0);
        if (req_ph && req_wait != 0) req_wait--;
        m_resp_valid = resp_ph && (rsp_gap == 0);
        if (resp_ph && rsp_gap != 0) rsp_gap--;
        if (m_resp_valid && rsp_wait != 0) begin
            s_resp_ready = 2'b00;
            rsp_wait--;
        end else begin
            s_resp_ready = 2'b11;
        end
        m_resp_data = m_resp_valid ? cur_resp : $urandom;
    endtask

    task automatic obs();
        logic [1:0] gnt;
        logic       w;
        bit         req_hs;
        bit         resp_hs;
        req_t       r;
        gnt = s_req_ready;
        w   = gnt[1];
        chk("grant_iff_idle_and_valid", 64'(gnt != 2'b00), 64'(!busy && s_req_valid != 2'b00));
        if (gnt != 2'b00) begin
            chk("grant_onehot", 64'($onehot(gnt)), 64'(1));
            chk("grant_expected", 64'(exp_order.size() != 0), 64'(1));
            if (exp_order.size() != 0) chk("grant_order", 64'(w), 64'(exp_order.pop_front()));
            r.id = w; r.addr = rq_addr[w]; r.wdata = rq_wdata[w]; r.wstrb = rq_wstrb[w];
            req_q.push_back(r);
        end
        chk("m_req_valid", 64'(m_req_valid), 64'(req_ph));
        if (req_ph && req_q.size() != 0) begin
            r = req_q[0];
            chk("m_req_id",    64'(m_req_id),    64'(r.id));
            chk("m_req_addr",  64'(m_req_addr),  64'(r.addr));
            chk("m_req_wdata", 64'(m_req_wdata), 64'(r.wdata));
            chk("m_req_wstrb", 64'(m_req_wstrb), 64'(r.wstrb));
        end
        chk("s_resp_valid", 64'(s_resp_valid),
            64'((resp_ph && m_resp_valid) ? (owner ? 2'b10 : 2'b01) : 2'b00));
        chk("m_resp_ready", 64'(m_resp_ready), 64'(resp_ph && s_resp_ready[owner]));
        chk("s_resp_data",  64'(s_resp_data),  64'(resp_ph ? m_resp_data : 32'h0));
        req_hs  = req_ph && m_req_ready;
        resp_hs = resp_ph && m_resp_valid && s_resp_ready[owner];
        if (resp_hs) begin
            resp_cnt[owner]++;
            last_data = s_resp_data;
            resp_ph   = 1'b0;
            busy      = 1'b0;
        end
        if (req_hs) begin
            void'(req_q.pop_front());
            req_ph   = 1'b0;
            resp_ph  = 1'b1;
            rsp_wait = resp_stall;
            rsp_gap  = txn_no % 2;
            cur_resp = 32'hcafe0a0a + 32'(txn_no);
            txn_no++;
        end
        if (gnt != 2'b00) begin
            busy     = 1'b1;
            owner    = w;
            req_ph   = 1'b1;
            req_wait = req_stall;
            gnt_last = gnt;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        obs();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || rq_cnt[0] != 0 || rq_cnt[1] != 0) && n < budget) begin
            cyc();
            n++;
        end
        chk({tag, "_idle_in_budget"}, 64'(busy || rq_cnt[0] != 0 || rq_cnt[1] != 0), 64'(0));
        chk({tag, "_order_done"}, 64'(exp_order.size()), 64'(0));
    endtask

    task automatic wait_phase(input bit want_resp, input int budget);
        int n = 0;
        while (!(want_resp ? resp_ph : req_ph) && n < budget) begin
            cyc();
            n++;
        end
        chk("phase_reached", 64'(want_resp ? resp_ph : req_ph), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        int b0;
        int b1;
        nrst = 1'b0;
        s_req_valid = '0; s_req_addr = '0; s_req_wdata = '0; s_req_wstrb = '0;
        s_resp_ready = '0; m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
        rq_cnt[0] = 0; rq_cnt[1] = 0; resp_cnt[0] = 0; resp_cnt[1] = 0;
        rq_addr[0] = 32'h00001000; rq_wdata[0] = 32'h0;        rq_wstrb[0] = 4'h0;
        rq_addr[1] = 32'h80000000; rq_wdata[1] = 32'h12345678; rq_wstrb[1] = 4'hf;
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        nrst = 1'b1;

        // Single I read returning 0xcafe0a0a.
        exp_order.push_back(1'b0);
        rq_cnt[0] = 1;
        run_until_idle("t1", 40);
        chk("t1_resp_i", 64'(resp_cnt[0]), 64'(1));
        chk("t1_resp_data", 64'(last_data), 64'(32'hcafe0a0a));

        // D write with downstream request stalled 5 cycles.
        b0 = resp_cnt[0]; b1 = resp_cnt[1];
        req_stall = 5;
        exp_order.push_back(1'b1);
        rq_cnt[1] = 1;
        run_until_idle("t2", 40);
        req_stall = 0;
        chk("t2_resp_d", 64'(resp_cnt[1] - b1), 64'(1));
        chk("t2_resp_i", 64'(resp_cnt[0] - b0), 64'(0));

        // Both requesters continuously valid.
`ifdef LADYBIRD_BUS_ARBITER_RR_EN
        exp_order.push_back(1'b0); exp_order.push_back(1'b1);
        exp_order.push_back(1'b0); exp_order.push_back(1'b1);
        rq_cnt[0] = 2; rq_cnt[1] = 2;
`else
        exp_order.push_back(1'b1); exp_order.push_back(1'b1);
        exp_order.push_back(1'b1); exp_order.push_back(1'b1);
        exp_order.push_back(1'b0);
        rq_cnt[0] = 1; rq_cnt[1] = 4;
`endif
        run_until_idle("t3", 120);

        // Response backpressure; D arrives while I is stuck in RESP.
        resp_stall = 3;
        exp_order.push_back(1'b0);
        rq_cnt[0] = 1;
        wait_phase(1'b1, 20);
        exp_order.push_back(1'b1);
        rq_cnt[1] = 1;
        run_until_idle("t4", 60);
        resp_stall = 0;

        // D arrives while I is still in REQ.
        req_stall = 2;
        exp_order.push_back(1'b0);
        rq_cnt[0] = 1;
        wait_phase(1'b0, 20);
        exp_order.push_back(1'b1);
        rq_cnt[1] = 1;
        run_until_idle("t5", 60);
        req_stall = 0;

        // Asynchronous reset in the middle of an I response.
        resp_stall = 20;
        exp_order.push_back(1'b0);
        rq_cnt[0] = 1;
        wait_phase(1'b1, 20);
        cyc();
        cyc();
        #2;
        nrst = 1'b0;
        s_req_valid = 2'b00; m_resp_valid = 1'b0; m_req_ready = 1'b0;
        #1;
        check_reset_outputs("mid_resp_rst");
        busy = 1'b0; req_ph = 1'b0; resp_ph = 1'b0; gnt_last = 2'b00;
        rq_cnt[0] = 0; rq_cnt[1] = 0; resp_stall = 0;
        req_q.delete();
        exp_order.delete();
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
`ifdef LADYBIRD_BUS_ARBITER_RR_EN
        exp_order.push_back(1'b0); exp_order.push_back(1'b1);
`else
        exp_order.push_back(1'b1); exp_order.push_back(1'b0);
`endif
        rq_cnt[0] = 1; rq_cnt[1] = 1;
        run_until_idle("t6", 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
